lsu_mem_initiator: RTL and testbench
====================================

Name: lsu_mem_initiator

Overview:
- Load/store initiator between the MEM pipeline stage and the byte-enabled data memory.
- Accepts one load/store request per transaction and derives the memory byte-enable and sign controls from size and address.
- Drives the memory port until it acknowledges, then returns read data or an exception to the pipeline.
- Detects misaligned accesses (AdEL/AdES) and memory timeouts (DBE) for the interrupt/exception unit, and supports a pipeline flush.

Parameters:
- TIMEOUT_CYCLES, 16: maximum ISSUE cycles waiting for mem_ready before a bus error is reported; 0 disables the timeout.
- CNT_W, 8: width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  pipeline request present
- req_ready  out  1  initiator can accept a request
- req_we  in  1  1=store, 0=load
- req_size  in  2  00=byte, 01=half, 10=word, 11=reserved
- req_unsigned  in  1  load zero-extends (lbu/lhu)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, unshifted (byte in [7:0], half in [15:0])
- flush  in  1  pipeline flush (exception/interrupt)
- resp_valid  out  1  one-cycle response strobe
- resp_rdata  out  32  extended load data; 0 for stores and exceptions
- resp_exc  out  1  response carries an exception
- resp_exc_code  out  5  4=AdEL, 5=AdES, 7=DBE, 10=reserved size
- resp_badvaddr  out  32  faulting address when resp_exc=1, else 0
- mem_en  out  1  memory access active
- mem_we  out  1  memory write
- mem_addr  out  32  word-addressed by memory (uses [31:2])
- mem_be  out  4  byte enable
- mem_sign  out  1  memory sign-extends load
- mem_wdata  out  32  passes req_wdata unshifted
- mem_rdata  in  32  memory read data, already extracted/extended
- mem_ready  in  1  memory completes access this cycle

Behaviour:
- Reset: state IDLE; all outputs 0, including req_ready while rst=1; timeout counter 0; kill flag 0.
- States: IDLE, ISSUE, RESP.
- req_ready = (state==IDLE) & ~flush & ~rst. A request is accepted on a rising edge where req_valid & req_ready.
- Byte enables:
  - byte: addr[1:0] 00/01/10/11 -> mem_be 0001/0010/0100/1000
  - half: addr[1]=0 -> 0011; addr[1]=1 -> 1100
  - word: 1111
- mem_sign = ~req_unsigned for loads; 0 for stores.
- Alignment: half requires addr[0]=0; word requires addr[1:0]=00.
- IDLE, accept, aligned, size != 11: latch all mem_* fields into registers; go to ISSUE.
- IDLE, accept, misaligned: go to RESP with exc code 4 (load) or 5 (store), badvaddr=req_addr; mem_en never asserted.
- IDLE, accept, size==11: go to RESP with exc code 10; mem_en never asserted.
- ISSUE:
  - mem_en=1 and mem_we=latched we; mem_* stable every cycle until completion.
  - On mem_ready=1: capture mem_rdata (loads only); mem_en drops next cycle; go to RESP, or to IDLE if kill=1.
  - Timeout counter increments each ISSUE cycle with mem_ready=0.
  - If TIMEOUT_CYCLES>0 and the counter reaches TIMEOUT_CYCLES: go to RESP with exc 7, badvaddr=latched addr; mem_en drops.
  - Counter clears on leaving ISSUE.
- RESP: resp_valid=1 for exactly one cycle with registered resp_* fields; then IDLE. resp_* return to 0 in IDLE.
- Flush:
  - IDLE: no request is accepted.
  - ISSUE: the memory access runs to completion (stores are not abortable); kill=1 suppresses RESP. The kill flag clears on entering IDLE.
  - RESP: no effect; the pipeline discards the strobe.
- Latency with mem_ready tied high: accept at edge N; mem_en high in cycle N+1; resp_valid in cycle N+2. Throughput is one request per 3 cycles.
- If mem_ready is asserted while mem_en=0, it is ignored.
- Asynchronous rst mid-transaction: immediately returns to IDLE with outputs 0; there is no completion guarantee for the in-flight store.

Test Plan:
- lb at addr 0x0000_0003, unsigned=0, mem_ready=1 -> mem_be=1000, mem_sign=1 in ISSUE; resp_valid 2 cycles after accept; resp_rdata=mem_rdata=0xFFFF_FF80.
- sh at 0x0000_0006, wdata 0x1234_ABCD -> mem_be=1100, mem_we=1, mem_wdata=0x1234_ABCD for one cycle; resp_exc=0, resp_rdata=0.
- lw at 0x0000_0002 -> no mem_en; resp_valid next cycle with exc=1, code=4, badvaddr=0x0000_0002. sh at 0x0000_0001 -> code=5.
- sw at 0x10, mem_ready held low with TIMEOUT_CYCLES=4 -> mem_en high for 4 cycles, then resp exc code=7, badvaddr=0x10; req_ready returns high the cycle after RESP.
- lhu at 0x8, mem_ready delayed 3 cycles, flush pulsed in the 2nd ISSUE cycle -> mem_en stays high until mem_ready; no resp_valid; req_ready high the following cycle.
- rst asserted during ISSUE -> mem_en, req_ready and resp_valid go to 0 asynchronously; after release, a new lw at 0x4 completes normally with mem_be=1111.

Source files
------------

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator between the MEM stage and the byte-enabled data memory.
// One transaction at a time: IDLE -> ISSUE (memory handshake) -> RESP (one-cycle strobe).
module lsu_mem_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        flush,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_exc,
  output logic [4:0]  resp_exc_code,
  output logic [31:0] resp_badvaddr,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic        mem_sign,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  localparam int unsigned TO_M1 = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_M1);
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);

  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_DBE  = 5'd7;
  localparam logic [4:0] EXC_RSV  = 5'd10;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             kill_q, kill_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [3:0]       be_q, be_d;
  logic             sign_q, sign_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             exc_q, exc_d;
  logic [4:0]       code_q, code_d;
  logic [31:0]      bad_q, bad_d;

  logic       accept;
  logic       misaligned;
  logic [3:0] req_be;

  assign req_ready = (state_q == IDLE) & ~flush & ~rst;
  assign accept    = req_valid & req_ready;

  always_comb begin
    req_be = 4'b0000;
    unique case (req_size)
      2'b00:   req_be = 4'b0001 << req_addr[1:0];
      2'b01:   req_be = req_addr[1] ? 4'b1100 : 4'b0011;
      2'b10:   req_be = 4'b1111;
      default: req_be = 4'b0000;
    endcase
  end

  assign misaligned = ((req_size == 2'b01) & req_addr[0]) |
                      ((req_size == 2'b10) & (req_addr[1:0] != 2'b00));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    kill_d  = kill_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    sign_d  = sign_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    exc_d   = exc_q;
    code_d  = code_q;
    bad_d   = bad_q;
    unique case (state_q)
      IDLE: begin
        kill_d  = 1'b0;
        cnt_d   = '0;
        rdata_d = '0;
        exc_d   = 1'b0;
        code_d  = '0;
        bad_d   = '0;
        if (accept) begin
          if (req_size == 2'b11) begin
            exc_d   = 1'b1;
            code_d  = EXC_RSV;
            bad_d   = req_addr;
            state_d = RESP;
          end else if (misaligned) begin
            exc_d   = 1'b1;
            code_d  = req_we ? EXC_ADES : EXC_ADEL;
            bad_d   = req_addr;
            state_d = RESP;
          end else begin
            we_d    = req_we;
            addr_d  = req_addr;
            be_d    = req_be;
            sign_d  = ~req_we & ~req_unsigned;
            wdata_d = req_wdata;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (flush) kill_d = 1'b1;
        if (mem_ready) begin
          rdata_d = we_q ? 32'h0 : mem_rdata;
          cnt_d   = '0;
          state_d = (kill_q | flush) ? IDLE : RESP;
        end else if (TO_EN && cnt_q == TO_LAST) begin
          exc_d   = 1'b1;
          code_d  = EXC_DBE;
          bad_d   = addr_q;
          cnt_d   = '0;
          state_d = (kill_q | flush) ? IDLE : RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        if (state_d == IDLE) kill_d = 1'b0;
      end
      RESP: begin
        kill_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      kill_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      sign_q  <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      exc_q   <= 1'b0;
      code_q  <= '0;
      bad_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      kill_q  <= kill_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      sign_q  <= sign_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      exc_q   <= exc_d;
      code_q  <= code_d;
      bad_q   <= bad_d;
    end
  end

  // Outputs are gated by state so everything reads 0 outside its own phase.
  assign mem_en    = (state_q == ISSUE);
  assign mem_we    = mem_en & we_q;
  assign mem_addr  = mem_en ? addr_q : 32'h0;
  assign mem_be    = mem_en ? be_q : 4'h0;
  assign mem_sign  = mem_en & sign_q;
  assign mem_wdata = mem_en ? wdata_q : 32'h0;

  assign resp_valid    = (state_q == RESP);
  assign resp_rdata    = resp_valid ? rdata_q : 32'h0;
  assign resp_exc      = resp_valid & exc_q;
  assign resp_exc_code = resp_valid ? code_q : 5'h0;
  assign resp_badvaddr = resp_valid ? bad_q : 32'h0;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed bench for lsu_mem_initiator: vector table plus timeout, flush and reset sequences.
module tb_lsu_mem_initiator;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        flush;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_exc;
  logic [4:0]  resp_exc_code;
  logic [31:0] resp_badvaddr;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic        mem_sign;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  int tests;
  int fails;

  lsu_mem_initiator #(
    .TIMEOUT_CYCLES(4),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we(req_we),
    .req_size(req_size),
    .req_unsigned(req_unsigned),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .flush(flush),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_exc(resp_exc),
    .resp_exc_code(resp_exc_code),
    .resp_badvaddr(resp_badvaddr),
    .mem_en(mem_en),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_be(mem_be),
    .mem_sign(mem_sign),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        exc;
    logic [4:0]  code;
    logic [3:0]  be;
    logic        sign;
    logic [31:0] resp;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_size = 2'b00;
    req_unsigned = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    flush = 1'b0;
    mem_rdata = '0;
    mem_ready = 1'b0;

    //        we    size   uns   addr          wdata         rdata         exc   code   be       sign  resp
    vecs[0] = '{1'b0, 2'b00, 1'b0, 32'h0000_0003, 32'h0,        32'hFFFF_FF80, 1'b0, 5'd0,  4'b1000, 1'b1, 32'hFFFF_FF80};
    vecs[1] = '{1'b1, 2'b01, 1'b0, 32'h0000_0006, 32'h1234_ABCD, 32'hDEAD_BEEF, 1'b0, 5'd0,  4'b1100, 1'b0, 32'h0};
    vecs[2] = '{1'b0, 2'b10, 1'b0, 32'h0000_0002, 32'h0,        32'h0,        1'b1, 5'd4,  4'b0000, 1'b0, 32'h0};
    vecs[3] = '{1'b1, 2'b01, 1'b0, 32'h0000_0001, 32'h5555_5555, 32'h0,        1'b1, 5'd5,  4'b0000, 1'b0, 32'h0};
    vecs[4] = '{1'b0, 2'b00, 1'b1, 32'h0000_0101, 32'h0,        32'h0000_007F, 1'b0, 5'd0,  4'b0010, 1'b0, 32'h0000_007F};
    vecs[5] = '{1'b0, 2'b01, 1'b0, 32'h0000_0200, 32'h0,        32'hFFFF_8001, 1'b0, 5'd0,  4'b0011, 1'b1, 32'hFFFF_8001};
    vecs[6] = '{1'b1, 2'b10, 1'b0, 32'h0000_0020, 32'hCAFE_F00D, 32'h1111_1111, 1'b0, 5'd0,  4'b1111, 1'b0, 32'h0};
    vecs[7] = '{1'b0, 2'b11, 1'b0, 32'h0000_0040, 32'h0,        32'h0,        1'b1, 5'd10, 4'b0000, 1'b0, 32'h0};
    vecs[8] = '{1'b1, 2'b00, 1'b0, 32'h0000_0302, 32'h0000_00A5, 32'h0,        1'b0, 5'd0,  4'b0100, 1'b0, 32'h0};
    vecs[9] = '{1'b0, 2'b10, 1'b0, 32'h0000_0003, 32'h0,        32'h0,        1'b1, 5'd4,  4'b0000, 1'b0, 32'h0};

    // Reset state
    #2;
    check("rst_req_ready", {31'b0, req_ready}, 32'h0);
    check("rst_mem_en", {31'b0, mem_en}, 32'h0);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
    tick();
    rst = 1'b0;
    #1;
    check("idle_req_ready", {31'b0, req_ready}, 32'h1);

    // Table: mem_ready tied high
    mem_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive_req(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata);
      mem_rdata = vecs[i].rdata;
      #1;
      check($sformatf("v%0d_req_ready", i), {31'b0, req_ready}, 32'h1);
      tick();
      req_valid = 1'b0;
      #1;
      if (vecs[i].exc) begin
        check($sformatf("v%0d_exc_mem_en", i), {31'b0, mem_en}, 32'h0);
        check($sformatf("v%0d_exc_valid", i), {31'b0, resp_valid}, 32'h1);
        check($sformatf("v%0d_exc", i), {31'b0, resp_exc}, 32'h1);
        check($sformatf("v%0d_code", i), {27'b0, resp_exc_code}, {27'b0, vecs[i].code});
        check($sformatf("v%0d_badvaddr", i), resp_badvaddr, vecs[i].addr);
        check($sformatf("v%0d_exc_rdata", i), resp_rdata, 32'h0);
      end else begin
        check($sformatf("v%0d_mem_en", i), {31'b0, mem_en}, 32'h1);
        check($sformatf("v%0d_mem_we", i), {31'b0, mem_we}, {31'b0, vecs[i].we});
        check($sformatf("v%0d_mem_be", i), {28'b0, mem_be}, {28'b0, vecs[i].be});
        check($sformatf("v%0d_mem_sign", i), {31'b0, mem_sign}, {31'b0, vecs[i].sign});
        check($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].addr);
        check($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].wdata);
        check($sformatf("v%0d_issue_valid", i), {31'b0, resp_valid}, 32'h0);
        tick();
        check($sformatf("v%0d_resp_valid", i), {31'b0, resp_valid}, 32'h1);
        check($sformatf("v%0d_resp_mem_en", i), {31'b0, mem_en}, 32'h0);
        check($sformatf("v%0d_resp_exc", i), {31'b0, resp_exc}, 32'h0);
        check($sformatf("v%0d_resp_rdata", i), resp_rdata, vecs[i].resp);
        check($sformatf("v%0d_resp_bad", i), resp_badvaddr, 32'h0);
      end
      tick();
      check($sformatf("v%0d_back_idle", i), {31'b0, req_ready}, 32'h1);
      check($sformatf("v%0d_idle_valid", i), {31'b0, resp_valid}, 32'h0);
    end

    // Timeout: sw 0x10 with memory never ready
    mem_ready = 1'b0;
    drive_req(1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'h0BAD_0BAD);
    tick();
    req_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      check($sformatf("to_mem_en_c%0d", c), {31'b0, mem_en}, 32'h1);
      tick();
    end
    #1;
    check("to_mem_en_drop", {31'b0, mem_en}, 32'h0);
    check("to_resp_valid", {31'b0, resp_valid}, 32'h1);
    check("to_exc", {31'b0, resp_exc}, 32'h1);
    check("to_code", {27'b0, resp_exc_code}, 32'd7);
    check("to_badvaddr", resp_badvaddr, 32'h0000_0010);
    check("to_req_ready_resp", {31'b0, req_ready}, 32'h0);
    tick();
    check("to_req_ready_after", {31'b0, req_ready}, 32'h1);

    // Flush during ISSUE: lhu 0x8, ready on 4th ISSUE cycle
    drive_req(1'b0, 2'b01, 1'b1, 32'h0000_0008, 32'h0);
    mem_rdata = 32'h0000_BEEF;
    tick();
    req_valid = 1'b0;
    check("fl_c1_mem_en", {31'b0, mem_en}, 32'h1);
    tick();
    flush = 1'b1;
    #1;
    check("fl_c2_mem_en", {31'b0, mem_en}, 32'h1);
    tick();
    flush = 1'b0;
    #1;
    check("fl_c3_mem_en", {31'b0, mem_en}, 32'h1);
    tick();
    mem_ready = 1'b1;
    #1;
    check("fl_c4_mem_en", {31'b0, mem_en}, 32'h1);
    tick();
    check("fl_no_resp", {31'b0, resp_valid}, 32'h0);
    check("fl_mem_en_off", {31'b0, mem_en}, 32'h0);
    check("fl_req_ready", {31'b0, req_ready}, 32'h1);

    // Flush blocks acceptance in IDLE
    flush = 1'b1;
    #1;
    check("fl_idle_ready", {31'b0, req_ready}, 32'h0);
    flush = 1'b0;
    tick();

    // Asynchronous reset mid-ISSUE, then a clean lw 0x4
    mem_ready = 1'b0;
    drive_req(1'b0, 2'b10, 1'b0, 32'h0000_0004, 32'h0);
    tick();
    req_valid = 1'b0;
    check("ar_issue_mem_en", {31'b0, mem_en}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("ar_mem_en", {31'b0, mem_en}, 32'h0);
    check("ar_req_ready", {31'b0, req_ready}, 32'h0);
    check("ar_resp_valid", {31'b0, resp_valid}, 32'h0);
    tick();
    rst = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = 32'h8765_4321;
    drive_req(1'b0, 2'b10, 1'b0, 32'h0000_0004, 32'h0);
    #1;
    check("ar2_req_ready", {31'b0, req_ready}, 32'h1);
    tick();
    req_valid = 1'b0;
    check("ar2_mem_en", {31'b0, mem_en}, 32'h1);
    check("ar2_mem_be", {28'b0, mem_be}, 32'hF);
    tick();
    check("ar2_resp_valid", {31'b0, resp_valid}, 32'h1);
    check("ar2_resp_rdata", resp_rdata, 32'h8765_4321);
    check("ar2_resp_exc", {31'b0, resp_exc}, 32'h0);
    tick();
    check("ar2_idle", {31'b0, req_ready}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
